// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Holds opcode constants, FSM state encodings, and the datapath control
// encodings (ALU op class, immediate ALU op, ALU B source, PC source).
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_I_WB     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WB   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_IMM   = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_ADD = 2'd0,
    IMM_SLT = 2'd1,
    IMM_OR  = 2'd2,
    IMM_AND = 2'd3
  } imm_op_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SL2 = 2'd3
  } src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_RSVD   = 2'd3
  } pc_src_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder used in the DECODE state.
// Ports:
//   opcode_i     - instruction opcode field
//   next_state_o - dispatch state for this opcode (FETCH when illegal)
//   sign_ext_o   - 1 = sign-extend immediate, 0 = zero-extend (andi/ori)
//   imm_op_o     - immediate ALU operation for I-type arithmetic/logic
//   illegal_o    - opcode is not supported
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode_i,
  output state_t          next_state_o,
  output logic            sign_ext_o,
  output imm_op_t         imm_op_o,
  output logic            illegal_o
);

  always_comb begin
    next_state_o = ST_FETCH;
    sign_ext_o   = 1'b1;
    imm_op_o     = IMM_ADD;
    illegal_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE:     next_state_o = ST_EXEC_R;
      OP_LW, OP_SW: next_state_o = ST_MEM_ADDR;
      OP_ADDI:      next_state_o = ST_EXEC_I;
      OP_SLTI: begin
        next_state_o = ST_EXEC_I;
        imm_op_o     = IMM_SLT;
      end
      OP_ANDI: begin
        next_state_o = ST_EXEC_I;
        sign_ext_o   = 1'b0;
        imm_op_o     = IMM_AND;
      end
      OP_ORI: begin
        next_state_o = ST_EXEC_I;
        sign_ext_o   = 1'b0;
        imm_op_o     = IMM_OR;
      end
      OP_BEQ, OP_BNE: next_state_o = ST_BRANCH;
      OP_J:           next_state_o = ST_JUMP;
      // Unsupported opcode: runs as a NOP, the PC was already advanced in FETCH.
      default:        illegal_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences
// fetch/decode/execute/memory/writeback over the shared ALU, register file
// and unified memory.
// Ports:
//   clk_i, rst_i           - clock (rising edge), async active-high reset
//   opcode_i               - IR[31:26], sampled in DECODE
//   zero_i                 - ALU zero flag, sampled in BRANCH
//   mem_ready_i            - memory access completes in the cycle it is high
//   pc_write_o..pc_src_o   - datapath mux selects and enables
//   illegal_o              - one-cycle pulse on an unsupported opcode
//   state_o                - current state, for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] opcode_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            ir_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            iord_o,
  output logic            reg_write_o,
  output logic            reg_dst_o,
  output logic            mem_to_reg_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      imm_op_o,
  output logic            sign_ext_sel_o,
  output logic [1:0]      pc_src_o,
  output logic            illegal_o,
  output logic [ST_W-1:0] state_o
);

  state_t          r_state;
  logic [OP_W-1:0] r_opcode;
  logic            r_sign_ext;
  imm_op_t         r_imm_op;

  state_t          w_dec_next;
  logic            w_dec_sext;
  imm_op_t         w_dec_imm;
  logic            w_dec_illegal;

  multicycle_ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .opcode_i     (opcode_i),
    .next_state_o (w_dec_next),
    .sign_ext_o   (w_dec_sext),
    .imm_op_o     (w_dec_imm),
    .illegal_o    (w_dec_illegal)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_opcode   <= '0;
      r_sign_ext <= 1'b0;
      r_imm_op   <= IMM_ADD;
    end else begin
      case (r_state)
        ST_IDLE:   r_state <= ST_FETCH;
        ST_FETCH:  if (mem_ready_i) r_state <= ST_DECODE;
        ST_DECODE: begin
          r_opcode   <= opcode_i;
          r_sign_ext <= w_dec_sext;
          r_imm_op   <= w_dec_imm;
          r_state    <= w_dec_next;
        end
        ST_EXEC_R:   r_state <= ST_R_WB;
        ST_R_WB:     r_state <= ST_FETCH;
        ST_EXEC_I:   r_state <= ST_I_WB;
        ST_I_WB:     r_state <= ST_FETCH;
        ST_MEM_ADDR: r_state <= (r_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (mem_ready_i) r_state <= ST_MEM_WB;
        ST_MEM_WB:   r_state <= ST_FETCH;
        ST_MEM_WR:   if (mem_ready_i) r_state <= ST_FETCH;
        ST_BRANCH:   r_state <= ST_FETCH;
        ST_JUMP:     r_state <= ST_FETCH;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write_o     = 1'b0;
    ir_write_o     = 1'b0;
    mem_read_o     = 1'b0;
    mem_write_o    = 1'b0;
    iord_o         = 1'b0;
    reg_write_o    = 1'b0;
    reg_dst_o      = 1'b0;
    mem_to_reg_o   = 1'b0;
    alu_src_a_o    = 1'b0;
    alu_src_b_o    = SRCB_RT;
    alu_op_o       = ALU_ADD;
    pc_src_o       = PCSRC_ALU;
    illegal_o      = 1'b0;
    // The extension registers keep their last DECODE value; mask them in IDLE
    // so that state presents all-zero outputs.
    sign_ext_sel_o = (r_state != ST_IDLE) ? r_sign_ext : 1'b0;
    imm_op_o       = (r_state != ST_IDLE) ? r_imm_op : IMM_ADD;
    state_o        = ST_W'(r_state);
    case (r_state)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_b_o = SRCB_IMM_SL2;
        illegal_o   = w_dec_illegal;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_IMM;
      end
      ST_I_WB:     reg_write_o = 1'b1;
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = PCSRC_ALUOUT;
        pc_write_o  = (r_opcode == OP_BNE) ? ~zero_i : zero_i;
      end
      ST_JUMP: begin
        pc_src_o   = PCSRC_JUMP;
        pc_write_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver applies one cycle of
// inputs and queues the hand-derived output vector for that cycle; the
// monitor pops and compares on the falling edge.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       rdy;

  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, sign_ext_sel, illegal;
  logic [1:0] alu_src_b, alu_op, imm_op, pc_src;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [22:0] exp;
  } item_t;
  item_t sb_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .opcode_i       (opcode),
    .zero_i         (zero),
    .mem_ready_i    (rdy),
    .pc_write_o     (pc_write),
    .ir_write_o     (ir_write),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .iord_o         (iord),
    .reg_write_o    (reg_write),
    .reg_dst_o      (reg_dst),
    .mem_to_reg_o   (mem_to_reg),
    .alu_src_a_o    (alu_src_a),
    .alu_src_b_o    (alu_src_b),
    .alu_op_o       (alu_op),
    .imm_op_o       (imm_op),
    .sign_ext_sel_o (sign_ext_sel),
    .pc_src_o       (pc_src),
    .illegal_o      (illegal),
    .state_o        (state)
  );

  logic [22:0] act;
  assign act = {state, pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_op,
                sign_ext_sel, pc_src, illegal};

  // Field order: state, pcw, irw, mrd, mwr, iord, rw, rdst, m2r, srca,
  //              srcb, aluop, immop, sext, pcsrc, illegal
  function automatic logic [22:0] mk(input state_t st,
      input bit pcw, input bit irw, input bit mr, input bit mw, input bit io,
      input bit rw, input bit rd, input bit m2r, input bit sa,
      input logic [1:0] sb, input logic [1:0] aop, input logic [1:0] iop,
      input bit sx, input logic [1:0] ps, input bit ill);
    return {st, pcw, irw, mr, mw, io, rw, rd, m2r, sa, sb, aop, iop, sx, ps, ill};
  endfunction

  task automatic step(input string tag, input logic r, input logic [5:0] op,
                      input logic z, input logic rd, input logic [22:0] e);
    item_t it;
    @(posedge clk);
    #1;
    rst = r; opcode = op; zero = z; rdy = rd;
    it.tag = tag;
    it.exp = e;
    sb_q.push_back(it);
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle,
  // plus the mutual-exclusion rules on the same sample.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s: got %h (state %0d) want %h (state %0d)",
                   it.tag, act, act[22:19], it.exp, it.exp[22:19]);
        end
        total++;
        if ((reg_write && mem_write) || (mem_read && mem_write)) begin
          bad++;
          $display("FAIL %s mutex: got rw=%0b mr=%0b mw=%0b want no overlap",
                   it.tag, reg_write, mem_read, mem_write);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; rdy = 1'b1;
    // Reset and R-type
    step("rst_held",  1, 6'h00, 0, 1, mk(ST_IDLE,    0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    step("rst_rel",   0, 6'h00, 0, 1, mk(ST_IDLE,    0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    step("r_fetch",   0, 6'h00, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,0,0,0));
    step("r_decode",  0, 6'h00, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,0,0,0));
    step("r_exec",    0, 6'h00, 0, 1, mk(ST_EXEC_R,  0,0,0,0,0,0,0,0,1, 0,2,0,1,0,0));
    step("r_wb",      0, 6'h00, 0, 1, mk(ST_R_WB,    0,0,0,0,0,1,1,0,0, 0,0,0,1,0,0));
    // ori: zero-extend, imm_op=or
    step("ori_fetch", 0, 6'h0D, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("ori_dec",   0, 6'h0D, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("ori_exec",  0, 6'h0D, 0, 1, mk(ST_EXEC_I,  0,0,0,0,0,0,0,0,1, 2,3,2,0,0,0));
    step("ori_wb",    0, 6'h0D, 0, 1, mk(ST_I_WB,    0,0,0,0,0,1,0,0,0, 0,0,2,0,0,0));
    // addi: sign-extend, imm_op=add
    step("addi_fetch",0, 6'h08, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,2,0,0,0));
    step("addi_dec",  0, 6'h08, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,2,0,0,0));
    step("addi_exec", 0, 6'h08, 0, 1, mk(ST_EXEC_I,  0,0,0,0,0,0,0,0,1, 2,3,0,1,0,0));
    step("addi_wb",   0, 6'h08, 0, 1, mk(ST_I_WB,    0,0,0,0,0,1,0,0,0, 0,0,0,1,0,0));
    // andi: zero-extend, imm_op=and
    step("andi_fetch",0, 6'h0C, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("andi_dec",  0, 6'h0C, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("andi_exec", 0, 6'h0C, 0, 1, mk(ST_EXEC_I,  0,0,0,0,0,0,0,0,1, 2,3,3,0,0,0));
    step("andi_wb",   0, 6'h0C, 0, 1, mk(ST_I_WB,    0,0,0,0,0,1,0,0,0, 0,0,3,0,0,0));
    // slti: sign-extend, imm_op=slt
    step("slti_fetch",0, 6'h0A, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,3,0,0,0));
    step("slti_dec",  0, 6'h0A, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,3,0,0,0));
    step("slti_exec", 0, 6'h0A, 0, 1, mk(ST_EXEC_I,  0,0,0,0,0,0,0,0,1, 2,3,1,1,0,0));
    step("slti_wb",   0, 6'h0A, 0, 1, mk(ST_I_WB,    0,0,0,0,0,1,0,0,0, 0,0,1,1,0,0));
    // lw with a fetch stall and three MEM_RD wait cycles
    step("lw_fstall", 0, 6'h23, 0, 0, mk(ST_FETCH,   0,0,1,0,0,0,0,0,0, 1,0,1,1,0,0));
    step("lw_fetch",  0, 6'h23, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,1,1,0,0));
    step("lw_dec",    0, 6'h23, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,1,1,0,0));
    step("lw_addr",   0, 6'h23, 0, 0, mk(ST_MEM_ADDR,0,0,0,0,0,0,0,0,1, 2,0,0,1,0,0));
    step("lw_rd_w1",  0, 6'h23, 0, 0, mk(ST_MEM_RD,  0,0,1,0,1,0,0,0,0, 0,0,0,1,0,0));
    step("lw_rd_w2",  0, 6'h23, 0, 0, mk(ST_MEM_RD,  0,0,1,0,1,0,0,0,0, 0,0,0,1,0,0));
    step("lw_rd_w3",  0, 6'h23, 0, 0, mk(ST_MEM_RD,  0,0,1,0,1,0,0,0,0, 0,0,0,1,0,0));
    step("lw_rd_ok",  0, 6'h23, 0, 1, mk(ST_MEM_RD,  0,0,1,0,1,0,0,0,0, 0,0,0,1,0,0));
    step("lw_wb",     0, 6'h23, 0, 1, mk(ST_MEM_WB,  0,0,0,0,0,1,0,1,0, 0,0,0,1,0,0));
    // beq taken, bne not taken (zero=1 both)
    step("beq_fetch", 0, 6'h04, 1, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("beq_dec",   0, 6'h04, 1, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("beq_br",    0, 6'h04, 1, 1, mk(ST_BRANCH,  1,0,0,0,0,0,0,0,1, 0,1,0,1,1,0));
    step("bne_fetch", 0, 6'h05, 1, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("bne_dec",   0, 6'h05, 1, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("bne_br",    0, 6'h05, 1, 1, mk(ST_BRANCH,  0,0,0,0,0,0,0,0,1, 0,1,0,1,1,0));
    // jump
    step("j_fetch",   0, 6'h02, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("j_dec",     0, 6'h02, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("j_jump",    0, 6'h02, 0, 1, mk(ST_JUMP,    1,0,0,0,0,0,0,0,0, 0,0,0,1,2,0));
    // illegal opcode: one-cycle pulse then straight back to FETCH
    step("ill_fetch", 0, 6'h3F, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    step("ill_dec",   0, 6'h3F, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,1));
    step("ill_after", 0, 6'h2B, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,1,0,0));
    // sw stalled in MEM_WR, then reset mid-stall
    step("sw_dec",    0, 6'h2B, 0, 1, mk(ST_DECODE,  0,0,0,0,0,0,0,0,0, 3,0,0,1,0,0));
    step("sw_addr",   0, 6'h2B, 0, 0, mk(ST_MEM_ADDR,0,0,0,0,0,0,0,0,1, 2,0,0,1,0,0));
    step("sw_wr_w1",  0, 6'h2B, 0, 0, mk(ST_MEM_WR,  0,0,0,1,1,0,0,0,0, 0,0,0,1,0,0));
    step("sw_wr_w2",  0, 6'h2B, 0, 0, mk(ST_MEM_WR,  0,0,0,1,1,0,0,0,0, 0,0,0,1,0,0));
    step("sw_rst",    1, 6'h2B, 0, 0, mk(ST_IDLE,    0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    step("sw_rst_rel",0, 6'h2B, 0, 1, mk(ST_IDLE,    0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    step("post_fetch",0, 6'h00, 0, 1, mk(ST_FETCH,   1,1,1,0,0,0,0,0,0, 1,0,0,0,0,0));

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the simple MIPS-subset CPU.
- Sequences fetch/decode/execute/memory/writeback over the shared ALU, register file and unified memory.
- Drives the immediate-extension select: sign-extend for arithmetic, load/store and branch; zero-extend for logical immediates (ori/andi).
- Sits between the instruction register opcode field and all datapath mux/enable controls.

Parameters:
- OP_W, 6, opcode field width (instr[31:26]).
- ST_W, 4, state register width; must encode all 13 states listed under Behaviour.

Ports:
- clk_i, input, 1, system clock; rising edge.
- rst_i, input, 1, asynchronous active-high reset.
- opcode_i, input, OP_W, IR[31:26]; sampled only in DECODE.
- zero_i, input, 1, ALU zero flag; sampled only in BRANCH.
- mem_ready_i, input, 1, memory handshake: access completes in the cycle it is high.
- pc_write_o, output, 1, PC load enable.
- ir_write_o, output, 1, IR load enable.
- mem_read_o, output, 1, memory read request.
- mem_write_o, output, 1, memory write request.
- iord_o, output, 1, memory address source: 0 = PC, 1 = ALUOut.
- reg_write_o, output, 1, register file write enable.
- reg_dst_o, output, 1, destination register: 0 = rt, 1 = rd.
- mem_to_reg_o, output, 1, writeback source: 0 = ALUOut, 1 = MDR.
- alu_src_a_o, output, 1, ALU A input: 0 = PC, 1 = rs.
- alu_src_b_o, output, 2, ALU B input: 0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm << 2.
- alu_op_o, output, 2, ALU op class: 0 = add, 1 = sub, 2 = funct, 3 = use imm_op_o.
- imm_op_o, output, 2, immediate ALU op: 0 = add, 1 = slt, 2 = or, 3 = and.
- sign_ext_sel_o, output, 1, extension select: 1 = sign, 0 = zero.
- pc_src_o, output, 2, PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- illegal_o, output, 1, one-cycle pulse on an unsupported opcode.
- state_o, output, ST_W, current state, for debug.

Behaviour:
- Reset: async on rst_i high; state = IDLE; every output 0.
- IDLE: all outputs 0; unconditionally goes to FETCH next cycle.
- Moore outputs: combinational decode of the state register; sign_ext_sel_o and imm_op_o come from a register loaded in DECODE.
- FETCH:
  - mem_read=1, iord=0, src_a=0, src_b=1, alu_op=0.
  - Holds while mem_ready_i=0.
  - On mem_ready_i=1: ir_write=1, pc_write=1, pc_src=0, same cycle; next state DECODE.
  - ir_write/pc_write never assert while ready is low.
- DECODE:
  - src_a=0, src_b=3, alu_op=0 (branch target into ALUOut).
  - Register extension select: 0 for op 0x0C (andi) and 0x0D (ori), 1 otherwise.
  - Register imm_op: addi=0, slti=1, ori=2, andi=3.
  - Dispatch: 0x00 -> EXEC_R; 0x23/0x2B -> MEM_ADDR; 0x08/0x0A/0x0C/0x0D -> EXEC_I; 0x04/0x05 -> BRANCH; 0x02 -> JUMP.
  - Any other opcode: illegal_o=1 for this cycle only, next state FETCH (executes as NOP; PC already advanced).
- EXEC_R: src_a=1, src_b=0, alu_op=2 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: src_a=1, src_b=2, alu_op=3 -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=0 -> MEM_RD for 0x23, MEM_WR for 0x2B. The opcode is held in an internal register from DECODE.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready_i -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready_i -> FETCH.
- BRANCH:
  - src_a=1, src_b=0, alu_op=1, pc_src=1.
  - pc_write = zero_i for beq, !zero_i for bne.
  - -> FETCH.
- JUMP: pc_src=2, pc_write=1 -> FETCH.
- Stalls: a mem_ready_i stall in FETCH/MEM_RD/MEM_WR keeps every output stable. No request drops while waiting.
- Mutual exclusion: reg_write and mem_write are never both 1. mem_read and mem_write are never both 1.
- Reset mid-operation: abandon immediately; return to IDLE with outputs 0 (including mid-stall).
- Illegal state encodings: go to IDLE.
- Latencies with zero wait states:
  - R-type / I-type / lw: 4 / 4 / 5 cycles.
  - sw: 4 cycles.
  - beq/bne / j: 3 / 3 cycles.

Decomposition:
- Shared package (defines include) holds:
  - opcode constants;
  - state encodings;
  - ALU_OP, IMM_OP, ALU_SRC_B and PC_SRC encodings.
- Natural sub-module: multicycle_ctrl_decode. It is combinational: opcode -> next dispatch state, ext select, imm_op, illegal.

Test Plan:
- Reset released, mem_ready_i=1, opcode 0x00 -> IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH. reg_write=1 and reg_dst=1 only in R_WB.
- ori (0x0D) then addi (0x08) -> sign_ext_sel_o=0 in EXEC_I/I_WB for ori, 1 for addi. imm_op_o=2 for ori, 0 for addi.
- lw with mem_ready_i low 3 cycles in MEM_RD -> mem_read=1 and iord=1 held 4 cycles; MEM_WB follows with mem_to_reg=1.
- beq with zero_i=1 -> pc_write=1, pc_src=1 in BRANCH. bne with zero_i=1 -> pc_write=0.
- opcode 0x3F -> illegal_o high exactly one cycle in DECODE, then FETCH; no reg_write or mem_write.
- rst_i asserted mid-MEM_WR stall -> next edge/async: mem_write=0, state_o=IDLE; FETCH one cycle after release.
